// File: rtl/des_pkg.sv
// des_pkg: shared constants for the DES key schedule.
//   PC1    - PC-1 selection table (56 entries, FIPS 1-based key bit numbers)
//   PC2    - PC-2 selection table (48 entries, 1-based C||D bit numbers)
//   SHIFTS - per-round rotation amounts s_1..s_16
//   state_t, rot_l/rot_r - schedule FSM states and C/D half rotations
package des_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ROUND = 1'b1
   } state_t;

   localparam int unsigned PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   localparam int unsigned SHIFTS [16] = '{
      1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
   };

   // FIPS bit 1 lives at index 0, so a FIPS left rotation moves bits
   // towards lower indices (a vector right rotation) and vice versa.
   function automatic logic [27:0] rot_l(input logic [27:0] x, input int unsigned n);
      return (n == 1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   function automatic logic [27:0] rot_r(input logic [27:0] x, input int unsigned n);
      return (n == 1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if: key-in / subkey-out handshake bundle.
//   key_valid/key_ready/key/decrypt      - key offer (master -> schedule)
//   sk_valid/sk_ready/subkey/sk_round/sk_last - subkey stream (schedule -> master)
//   parity_err, busy                     - status from the schedule
interface des_key_schedule_if;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key;
   logic        decrypt;
   logic        sk_valid;
   logic        sk_ready;
   logic [47:0] subkey;
   logic [3:0]  sk_round;
   logic        sk_last;
   logic        parity_err;
   logic        busy;

   modport master (
      output key_valid, key, decrypt, sk_ready,
      input  key_ready, sk_valid, subkey, sk_round, sk_last, parity_err, busy
   );

   modport slave (
      input  key_valid, key, decrypt, sk_ready,
      output key_ready, sk_valid, subkey, sk_round, sk_last, parity_err, busy
   );
endinterface

// File: rtl/des_pc2.sv
// des_pc2: combinational PC-2 compression, 56 -> 48 bits.
//   cd - C||D with C at [27:0], D at [55:28] (index i = FIPS bit i+1)
//   k  - round subkey (index i = PC-2 output bit i+1)
module des_pc2 (
   input  logic [55:0] cd,
   output logic [47:0] k
);
   import des_pkg::*;

   for (genvar g = 0; g < 48; g++) begin : g_pc2
      assign k[g] = cd[PC2[g] - 1];
   end
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES key schedule.
//   clk, rst_n - clock, asynchronous active-low reset
//   kif        - slave side of des_key_schedule_if: accepts a 64-bit key
//                (optionally parity-checked) and streams 16 subkeys in
//                encrypt (K1..K16) or decrypt (K16..K1) order
module des_key_schedule #(
   parameter bit PARITY_CHECK = 1'b1,
   parameter bit DEC_SUPPORT  = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   des_key_schedule_if.slave kif
);
   import des_pkg::*;

   state_t      state, state_nxt;
   logic [27:0] c, d, c_nxt, d_nxt;
   logic [3:0]  rnd, rnd_nxt;
   logic        dec, dec_nxt;
   logic        perr, perr_nxt;
   logic [55:0] pc1_out;
   logic [7:0]  byte_par;
   logic        key_bad;
   logic        dec_req;
   logic [3:0]  enc_idx;
   logic [3:0]  dec_idx;

   for (genvar g = 0; g < 56; g++) begin : g_pc1
      assign pc1_out[g] = kif.key[PC1[g] - 1];
   end

   for (genvar g = 0; g < 8; g++) begin : g_par
      assign byte_par[g] = ^kif.key[8*g +: 8];
   end

   assign key_bad = PARITY_CHECK && !(&byte_par);
   assign dec_req = DEC_SUPPORT && kif.decrypt;

   // rnd holds r-1; advancing to round r' = rnd+2 needs s_{r'} for encrypt
   // and s_{18-r'} for decrypt, i.e. SHIFTS[rnd+1] and SHIFTS[15-rnd].
   assign enc_idx = rnd + 4'd1;
   assign dec_idx = 4'd15 - rnd;

   always_comb begin
      state_nxt = state;
      c_nxt     = c;
      d_nxt     = d;
      rnd_nxt   = rnd;
      dec_nxt   = dec;
      perr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (kif.key_valid) begin
               if (key_bad) begin
                  perr_nxt = 1'b1;
               end else begin
                  state_nxt = ROUND;
                  rnd_nxt   = '0;
                  dec_nxt   = dec_req;
                  if (dec_req) begin
                     // Total rotation over 16 rounds is 28: K16 uses PC-1 halves as-is.
                     c_nxt = pc1_out[27:0];
                     d_nxt = pc1_out[55:28];
                  end else begin
                     c_nxt = rot_l(pc1_out[27:0], SHIFTS[0]);
                     d_nxt = rot_l(pc1_out[55:28], SHIFTS[0]);
                  end
               end
            end
         end
         ROUND: begin
            if (kif.sk_ready) begin
               if (rnd == 4'd15) begin
                  state_nxt = IDLE;
               end else begin
                  rnd_nxt = rnd + 4'd1;
                  if (dec) begin
                     c_nxt = rot_r(c, SHIFTS[dec_idx]);
                     d_nxt = rot_r(d, SHIFTS[dec_idx]);
                  end else begin
                     c_nxt = rot_l(c, SHIFTS[enc_idx]);
                     d_nxt = rot_l(d, SHIFTS[enc_idx]);
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         c     <= '0;
         d     <= '0;
         rnd   <= '0;
         dec   <= 1'b0;
         perr  <= 1'b0;
      end else begin
         state <= state_nxt;
         c     <= c_nxt;
         d     <= d_nxt;
         rnd   <= rnd_nxt;
         dec   <= dec_nxt;
         perr  <= perr_nxt;
      end
   end

   des_pc2 u_pc2 (
      .cd ({d, c}),
      .k  (kif.subkey)
   );

   assign kif.key_ready  = (state == IDLE);
   assign kif.busy       = (state == ROUND);
   assign kif.sk_valid   = (state == ROUND);
   assign kif.sk_round   = rnd;
   assign kif.sk_last    = (state == ROUND) && (rnd == 4'd15);
   assign kif.parity_err = perr;
endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;
   logic        clk;
   logic        rst_n;
   logic        key_valid;
   logic        decrypt;
   logic        sk_ready;
   logic [63:0] key;
   logic [1:0]  sel;

   logic        o_key_ready, o_sk_valid, o_sk_last, o_parity_err, o_busy;
   logic [47:0] o_subkey;
   logic [3:0]  o_sk_round;

   int tests = 0;
   int fails = 0;

   logic [47:0] got_sk[$];
   logic [3:0]  got_rd[$];
   logic        got_last[$];
   logic [47:0] enc_seq[$];
   logic [47:0] base_seq[$];
   int unstable, kr_cycle, kr_early, extra_valid;

   int pc1q[$] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                   10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                   63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                   14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   int pc2q[$] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                   23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                   41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                   44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   int shq[$]  = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   des_key_schedule_if ifa ();
   des_key_schedule_if ifb ();
   des_key_schedule_if ifc ();

   assign ifa.key_valid = key_valid && (sel == 2'd0);
   assign ifb.key_valid = key_valid && (sel == 2'd1);
   assign ifc.key_valid = key_valid && (sel == 2'd2);
   assign ifa.key = key;  assign ifb.key = key;  assign ifc.key = key;
   assign ifa.decrypt = decrypt;  assign ifb.decrypt = decrypt;  assign ifc.decrypt = decrypt;
   assign ifa.sk_ready = sk_ready;  assign ifb.sk_ready = sk_ready;  assign ifc.sk_ready = sk_ready;

   des_key_schedule #(.PARITY_CHECK(1'b1), .DEC_SUPPORT(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .kif(ifa));
   des_key_schedule #(.PARITY_CHECK(1'b0), .DEC_SUPPORT(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .kif(ifb));
   des_key_schedule #(.PARITY_CHECK(1'b1), .DEC_SUPPORT(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .kif(ifc));

   always_comb begin
      case (sel)
         2'd1: begin
            o_key_ready = ifb.key_ready; o_sk_valid = ifb.sk_valid; o_sk_last = ifb.sk_last;
            o_parity_err = ifb.parity_err; o_busy = ifb.busy; o_subkey = ifb.subkey; o_sk_round = ifb.sk_round;
         end
         2'd2: begin
            o_key_ready = ifc.key_ready; o_sk_valid = ifc.sk_valid; o_sk_last = ifc.sk_last;
            o_parity_err = ifc.parity_err; o_busy = ifc.busy; o_subkey = ifc.subkey; o_sk_round = ifc.sk_round;
         end
         default: begin
            o_key_ready = ifa.key_ready; o_sk_valid = ifa.sk_valid; o_sk_last = ifa.sk_last;
            o_parity_err = ifa.parity_err; o_busy = ifa.busy; o_subkey = ifa.subkey; o_sk_round = ifa.sk_round;
         end
      endcase
   end

   function automatic logic [63:0] bitrev64(input logic [63:0] x);
      logic [63:0] r, xx;
      r = '0; xx = x;
      for (int i = 0; i < 64; i++) begin
         r  = {r[62:0], xx[0]};
         xx = {1'b0, xx[63:1]};
      end
      return r;
   endfunction

   function automatic logic [47:0] bitrev48(input logic [47:0] x);
      logic [47:0] r, xx;
      r = '0; xx = x;
      for (int i = 0; i < 48; i++) begin
         r  = {r[46:0], xx[0]};
         xx = {1'b0, xx[47:1]};
      end
      return r;
   endfunction

   // Force odd parity in every byte (parity bit = bit 7 of each byte).
   function automatic logic [63:0] fix_par(input logic [63:0] k);
      logic [63:0] r;
      logic [7:0]  by;
      r = k;
      for (int b = 0; b < 8; b++) begin
         by = 8'(r >> (8*b));
         if (^by == 1'b0) r = r ^ (64'h80 << (8*b));
      end
      return r;
   endfunction

   // Subkey K_n straight from the FIPS definition: C_n[i] = C_0[i + cumulative shift].
   function automatic logic [47:0] ref_key(input logic [63:0] k, input int n);
      int cum, pos, src;
      logic [63:0] kb;
      logic [47:0] r;
      cum = 0;
      for (int i = 0; i < n; i++) cum += shq[i];
      r = '0;
      for (int j = 0; j < 48; j++) begin
         pos = pc2q[j];
         if (pos <= 28) src = pc1q[(pos - 1 + cum) % 28];
         else           src = pc1q[28 + (pos - 29 + cum) % 28];
         kb = k >> (src - 1);
         r  = {kb[0], r[47:1]};
      end
      return r;
   endfunction

   function automatic logic [63:0] rand_key();
      logic [63:0] k;
      k = {$urandom, $urandom};
      return fix_par(k);
   endfunction

   // Offers one key and collects the subkey stream; records what it observed.
   task automatic run_sched(input logic [63:0] k, input logic dec, input int unsigned stall_pct, input bit hold_kv);
      int cyc;
      bit stalled;
      logic [47:0] p_sk;
      logic [3:0]  p_rd;
      logic        p_last;
      got_sk.delete(); got_rd.delete(); got_last.delete();
      unstable = 0; kr_cycle = -1; kr_early = 0; extra_valid = 0;
      stalled = 1'b0; p_sk = '0; p_rd = '0; p_last = 1'b0;
      cyc = 0;
      while (o_key_ready !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      key = k; decrypt = dec; key_valid = 1'b1; sk_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (hold_kv) begin
         key = ~k; decrypt = ~dec;
      end else begin
         key_valid = 1'b0;
      end
      cyc = 1;
      while (cyc < 200) begin
         if (stalled && (o_sk_valid !== 1'b1 || o_subkey !== p_sk || o_sk_round !== p_rd || o_sk_last !== p_last))
            unstable++;
         stalled = 1'b0;
         if (got_sk.size() == 16) begin
            sk_ready = 1'b0;
            if (o_sk_valid !== 1'b0) extra_valid++;
            if (o_key_ready === 1'b1) begin
               kr_cycle = cyc;
               break;
            end
         end else begin
            if (o_key_ready !== 1'b0) kr_early++;
            if (o_sk_valid === 1'b1) begin
               if ($urandom_range(99) >= stall_pct) begin
                  sk_ready = 1'b1;
                  got_sk.push_back(o_subkey);
                  got_rd.push_back(o_sk_round);
                  got_last.push_back(o_sk_last);
                  if (got_sk.size() == 16) key_valid = 1'b0;
               end else begin
                  sk_ready = 1'b0;
                  stalled = 1'b1;
                  p_sk = o_subkey; p_rd = o_sk_round; p_last = o_sk_last;
               end
            end else begin
               sk_ready = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      sk_ready = 1'b0;
      key_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; key_valid = 1'b0; sk_ready = 1'b0; key = '0; decrypt = 1'b0; sel = 2'd0;
      repeat (3) @(negedge clk);
      tests++; if (o_sk_valid !== 1'b0) begin fails++; $display("FAIL reset_sk_valid: got %b want 0", o_sk_valid); end
      tests++; if (o_subkey !== 48'h0) begin fails++; $display("FAIL reset_subkey: got %h want 0", o_subkey); end
      tests++; if (o_sk_round !== 4'd0) begin fails++; $display("FAIL reset_sk_round: got %0d want 0", o_sk_round); end
      tests++; if (o_sk_last !== 1'b0) begin fails++; $display("FAIL reset_sk_last: got %b want 0", o_sk_last); end
      tests++; if (o_parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err: got %b want 0", o_parity_err); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if (o_key_ready !== 1'b1) begin fails++; $display("FAIL reset_key_ready: got %b want 1", o_key_ready); end
   endtask

   task automatic test_fips_encrypt();
      logic [63:0] k;
      logic [47:0] k1, k16;
      k = bitrev64(64'h133457799BBCDFF1);
      k1 = bitrev48(48'h1B02EFFC7072);
      k16 = bitrev48(48'hCB3D8B0E17F5);
      sel = 2'd0;
      run_sched(k, 1'b0, 0, 1'b0);
      tests++; if (got_sk.size() != 16) begin fails++; $display("FAIL enc_count: got %0d want 16", got_sk.size()); end
      if (got_sk.size() == 16) begin
         tests++; if (got_sk[0] !== k1) begin fails++; $display("FAIL enc_fips_k1: got %h want %h", got_sk[0], k1); end
         tests++; if (got_sk[15] !== k16) begin fails++; $display("FAIL enc_fips_k16: got %h want %h", got_sk[15], k16); end
         enc_seq.delete();
         for (int i = 0; i < 16; i++) begin
            enc_seq.push_back(got_sk[i]);
            tests++; if (got_sk[i] !== ref_key(k, i + 1)) begin fails++; $display("FAIL enc_subkey[%0d]: got %h want %h", i, got_sk[i], ref_key(k, i + 1)); end
            tests++; if (got_rd[i] !== 4'(i)) begin fails++; $display("FAIL enc_round[%0d]: got %0d want %0d", i, got_rd[i], i); end
            tests++; if (got_last[i] !== (i == 15)) begin fails++; $display("FAIL enc_last[%0d]: got %b want %b", i, got_last[i], (i == 15)); end
         end
      end
      tests++; if (kr_cycle != 17) begin fails++; $display("FAIL enc_key_ready_cycle: got %0d want 17", kr_cycle); end
      tests++; if (kr_early != 0) begin fails++; $display("FAIL enc_key_ready_busy: got %0d want 0", kr_early); end
      tests++; if (extra_valid != 0) begin fails++; $display("FAIL enc_extra_valid: got %0d want 0", extra_valid); end
   endtask

   task automatic test_fips_decrypt();
      logic [63:0] k;
      logic [47:0] k1, k16;
      k = bitrev64(64'h133457799BBCDFF1);
      k1 = bitrev48(48'h1B02EFFC7072);
      k16 = bitrev48(48'hCB3D8B0E17F5);
      sel = 2'd0;
      run_sched(k, 1'b1, 0, 1'b0);
      tests++; if (got_sk.size() != 16) begin fails++; $display("FAIL dec_count: got %0d want 16", got_sk.size()); end
      if (got_sk.size() == 16 && enc_seq.size() == 16) begin
         tests++; if (got_sk[0] !== k16) begin fails++; $display("FAIL dec_fips_first: got %h want %h", got_sk[0], k16); end
         tests++; if (got_sk[15] !== k1) begin fails++; $display("FAIL dec_fips_last: got %h want %h", got_sk[15], k1); end
         for (int i = 0; i < 16; i++) begin
            tests++; if (got_sk[i] !== enc_seq[15 - i]) begin fails++; $display("FAIL dec_reverse[%0d]: got %h want %h", i, got_sk[i], enc_seq[15 - i]); end
            tests++; if (got_sk[i] !== ref_key(k, 16 - i)) begin fails++; $display("FAIL dec_subkey[%0d]: got %h want %h", i, got_sk[i], ref_key(k, 16 - i)); end
         end
         tests++; if (got_last[15] !== 1'b1) begin fails++; $display("FAIL dec_last: got %b want 1", got_last[15]); end
      end
      tests++; if (kr_cycle != 17) begin fails++; $display("FAIL dec_key_ready_cycle: got %0d want 17", kr_cycle); end
   endtask

   task automatic test_random_stall();
      logic [63:0] k;
      logic        dec;
      sel = 2'd0;
      for (int t = 0; t < 6; t++) begin
         k = rand_key();
         dec = 1'($urandom_range(1));
         run_sched(k, dec, 0, 1'b0);
         base_seq.delete();
         foreach (got_sk[i]) base_seq.push_back(got_sk[i]);
         run_sched(k, dec, 30, 1'b1);
         tests++; if (got_sk.size() != 16) begin fails++; $display("FAIL stall_count t%0d: got %0d want 16", t, got_sk.size()); end
         tests++; if (unstable != 0) begin fails++; $display("FAIL stall_stable t%0d: got %0d changes want 0", t, unstable); end
         tests++; if (kr_early != 0) begin fails++; $display("FAIL stall_key_ready_busy t%0d: got %0d want 0", t, kr_early); end
         if (got_sk.size() == 16 && base_seq.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
               tests++; if (got_sk[i] !== base_seq[i]) begin fails++; $display("FAIL stall_vs_unstalled t%0d[%0d]: got %h want %h", t, i, got_sk[i], base_seq[i]); end
               tests++; if (got_sk[i] !== ref_key(k, dec ? 16 - i : i + 1)) begin fails++; $display("FAIL stall_subkey t%0d[%0d]: got %h want %h", t, i, got_sk[i], ref_key(k, dec ? 16 - i : i + 1)); end
            end
         end
      end
   endtask

   task automatic test_parity();
      int nv, nr, cyc, b;
      sel = 2'd0;
      for (int t = 0; t < 2; t++) begin
         b = $urandom_range(7);
         key = (t == 0) ? 64'h0 : (rand_key() ^ (64'h1 << (8*b)));
         decrypt = 1'b0;
         cyc = 0;
         while (o_key_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
         key_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         key_valid = 1'b0;
         tests++; if (o_parity_err !== 1'b1) begin fails++; $display("FAIL par_err_pulse t%0d: got %b want 1", t, o_parity_err); end
         tests++; if (o_sk_valid !== 1'b0) begin fails++; $display("FAIL par_no_valid t%0d: got %b want 0", t, o_sk_valid); end
         tests++; if (o_key_ready !== 1'b1) begin fails++; $display("FAIL par_key_ready t%0d: got %b want 1", t, o_key_ready); end
         @(negedge clk);
         tests++; if (o_parity_err !== 1'b0) begin fails++; $display("FAIL par_err_one_cycle t%0d: got %b want 0", t, o_parity_err); end
         nv = 0; nr = 0;
         repeat (20) begin
            if (o_sk_valid !== 1'b0) nv++;
            if (o_key_ready !== 1'b1) nr++;
            @(negedge clk);
         end
         tests++; if (nv != 0) begin fails++; $display("FAIL par_quiet_valid t%0d: got %0d want 0", t, nv); end
         tests++; if (nr != 0) begin fails++; $display("FAIL par_quiet_ready t%0d: got %0d want 0", t, nr); end
      end
      sel = 2'd1;
      run_sched(64'h0, 1'b0, 0, 1'b0);
      tests++; if (got_sk.size() != 16) begin fails++; $display("FAIL nopar_count: got %0d want 16", got_sk.size()); end
      foreach (got_sk[i]) begin
         tests++; if (got_sk[i] !== 48'h0) begin fails++; $display("FAIL nopar_zero[%0d]: got %h want 0", i, got_sk[i]); end
      end
      tests++; if (kr_cycle != 17) begin fails++; $display("FAIL nopar_key_ready_cycle: got %0d want 17", kr_cycle); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] k, k2;
      int cyc, nv;
      sel = 2'd0;
      k = rand_key();
      key = k; decrypt = 1'b0;
      cyc = 0;
      while (o_key_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      key_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      sk_ready = 1'b1;
      cyc = 0;
      while (o_sk_round !== 4'd7 && cyc < 50) begin @(negedge clk); cyc++; end
      tests++; if (o_sk_round !== 4'd7 || o_sk_valid !== 1'b1) begin fails++; $display("FAIL mid_reach_round7: got round %0d valid %b want 7/1", o_sk_round, o_sk_valid); end
      tests++; if (o_subkey !== ref_key(k, 8)) begin fails++; $display("FAIL mid_round7_subkey: got %h want %h", o_subkey, ref_key(k, 8)); end
      rst_n = 1'b0;
      #1;
      tests++; if (o_sk_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", o_sk_valid); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
      tests++; if (o_subkey !== 48'h0) begin fails++; $display("FAIL mid_rst_subkey: got %h want 0", o_subkey); end
      tests++; if (o_sk_round !== 4'd0) begin fails++; $display("FAIL mid_rst_round: got %0d want 0", o_sk_round); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      repeat (10) begin
         @(negedge clk);
         if (o_sk_valid !== 1'b0) nv++;
      end
      sk_ready = 1'b0;
      tests++; if (nv != 0) begin fails++; $display("FAIL mid_no_valid_after: got %0d want 0", nv); end
      k2 = rand_key();
      run_sched(k2, 1'b0, 0, 1'b0);
      tests++; if (got_sk.size() != 16) begin fails++; $display("FAIL mid_new_count: got %0d want 16", got_sk.size()); end
      if (got_sk.size() > 0) begin
         tests++; if (got_sk[0] !== ref_key(k2, 1)) begin fails++; $display("FAIL mid_new_k1: got %h want %h", got_sk[0], ref_key(k2, 1)); end
      end
   endtask

   task automatic test_dec_disabled();
      logic [63:0] k;
      sel = 2'd2;
      k = rand_key();
      run_sched(k, 1'b1, 0, 1'b0);
      tests++; if (got_sk.size() != 16) begin fails++; $display("FAIL nodec_count: got %0d want 16", got_sk.size()); end
      foreach (got_sk[i]) begin
         tests++; if (got_sk[i] !== ref_key(k, i + 1)) begin fails++; $display("FAIL nodec_order[%0d]: got %h want %h", i, got_sk[i], ref_key(k, i + 1)); end
      end
   endtask

   initial begin
      test_reset();
      test_fips_encrypt();
      test_fips_decrypt();
      test_random_stall();
      test_parity();
      test_reset_mid();
      test_dec_disabled();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end
endmodule
